// File: rtl/flash_op_sequencer.sv
// rtl/flash_op_sequencer.sv - sequences one flash read/program/erase over the shared SPI controller
//
// Requester side : req_valid/req_ready handshake with req_op/req_addr/req_len,
//                  op_done one-cycle completion pulse with op_err
//                  (op_err = poll timeout or reserved op).
// Controller side: spi_start pulse plus spi_opcode/spi_addr/spi_len/spi_rw command fields,
//                  spi_busy back-pressure, spi_done completion and spi_rdata status byte.
// Program and erase are preceded by WREN and followed by RDSR polling (spaced by POLL_GAP
// idle cycles) until WIP clears, or until MAX_POLLS polls have been spent.
module flash_op_sequencer #(
    parameter int POLL_GAP  = 16,
    parameter int MAX_POLLS = 1024,
    parameter int PCW       = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [23:0] req_addr,
    input  logic [3:0]  req_len,
    output logic        op_done,
    output logic        op_err,
    output logic        spi_start,
    output logic [7:0]  spi_opcode,
    output logic [23:0] spi_addr,
    output logic [3:0]  spi_len,
    output logic        spi_rw,
    input  logic        spi_busy,
    input  logic        spi_done,
    input  logic [7:0]  spi_rdata
);
    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_PP   = 2'b01;
    localparam logic [1:0] OP_SE   = 2'b10;

    localparam logic [7:0] OPC_READ = 8'h03;
    localparam logic [7:0] OPC_PP   = 8'h02;
    localparam logic [7:0] OPC_SE   = 8'h20;
    localparam logic [7:0] OPC_WREN = 8'h06;
    localparam logic [7:0] OPC_RDSR = 8'h05;

    localparam int GCW = $clog2(POLL_GAP + 1);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'(POLL_GAP - 1);
    localparam logic [PCW-1:0] POLL_LAST = PCW'(MAX_POLLS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WREN,
        S_CMD,
        S_GAP,
        S_POLL,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [23:0] addr;
        logic [3:0]  len;
        logic        rw;
    } spi_cmd_t;

    localparam spi_cmd_t WREN_CMD = {OPC_WREN, 24'd0, 4'd0, 1'b0};
    localparam spi_cmd_t RDSR_CMD = {OPC_RDSR, 24'd0, 4'd1, 1'b1};

    function automatic spi_cmd_t main_cmd(input logic [1:0] op, input logic [23:0] addr,
                                          input logic [3:0] len);
        spi_cmd_t c;
        c.addr = addr;
        case (op)
            OP_READ: begin c.opcode = OPC_READ; c.len = len;  c.rw = 1'b1; end
            OP_PP:   begin c.opcode = OPC_PP;   c.len = len;  c.rw = 1'b0; end
            default: begin c.opcode = OPC_SE;   c.len = 4'd0; c.rw = 1'b0; end
        endcase
        return c;
    endfunction

    state_t           state;
    logic             issued;     // spi_start already given for the current issuing state
    logic [1:0]       op_q;
    logic [23:0]      addr_q;
    logic [3:0]       len_q;
    logic [PCW-1:0]   poll_cnt;
    logic [GCW-1:0]   gap_cnt;
    logic [PCW-1:0]   poll_nxt;

    assign poll_nxt = poll_cnt + PCW'(1);

    // Only the WIP bit of the status byte matters here.
    logic unused_rdata;
    assign unused_rdata = ^spi_rdata[7:1];

    // Entering an issuing state launches at the same edge when the controller is free;
    // otherwise the state retries every cycle until spi_busy drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            issued     <= 1'b0;
            op_q       <= 2'b00;
            addr_q     <= 24'd0;
            len_q      <= 4'd0;
            poll_cnt   <= '0;
            gap_cnt    <= '0;
            req_ready  <= 1'b1;
            op_done    <= 1'b0;
            op_err     <= 1'b0;
            spi_start  <= 1'b0;
            spi_opcode <= 8'd0;
            spi_addr   <= 24'd0;
            spi_len    <= 4'd0;
            spi_rw     <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            op_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        addr_q    <= req_addr;
                        len_q     <= req_len;
                        req_ready <= 1'b0;
                        poll_cnt  <= '0;
                        gap_cnt   <= '0;
                        case (req_op)
                            OP_READ: begin
                                state <= S_CMD;
                                {spi_opcode, spi_addr, spi_len, spi_rw} <= main_cmd(req_op, req_addr, req_len);
                                spi_start <= ~spi_busy;
                                issued    <= ~spi_busy;
                            end
                            OP_PP, OP_SE: begin
                                state <= S_WREN;
                                {spi_opcode, spi_addr, spi_len, spi_rw} <= WREN_CMD;
                                spi_start <= ~spi_busy;
                                issued    <= ~spi_busy;
                            end
                            default: begin
                                // Reserved op: report an error without touching the bus.
                                state   <= S_DONE;
                                op_done <= 1'b1;
                                op_err  <= 1'b1;
                            end
                        endcase
                    end
                end
                S_WREN: begin
                    if (!issued) begin
                        spi_start <= ~spi_busy;
                        issued    <= ~spi_busy;
                    end else if (spi_done) begin
                        state <= S_CMD;
                        {spi_opcode, spi_addr, spi_len, spi_rw} <= main_cmd(op_q, addr_q, len_q);
                        spi_start <= ~spi_busy;
                        issued    <= ~spi_busy;
                    end
                end
                S_CMD: begin
                    if (!issued) begin
                        spi_start <= ~spi_busy;
                        issued    <= ~spi_busy;
                    end else if (spi_done) begin
                        issued <= 1'b0;
                        if (op_q == OP_READ) begin
                            state   <= S_DONE;
                            op_done <= 1'b1;
                            op_err  <= 1'b0;
                        end else begin
                            state    <= S_GAP;
                            poll_cnt <= '0;
                            gap_cnt  <= '0;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_POLL;
                        {spi_opcode, spi_addr, spi_len, spi_rw} <= RDSR_CMD;
                        spi_start <= ~spi_busy;
                        issued    <= ~spi_busy;
                    end else begin
                        gap_cnt <= gap_cnt + GCW'(1);
                    end
                end
                S_POLL: begin
                    if (!issued) begin
                        spi_start <= ~spi_busy;
                        issued    <= ~spi_busy;
                    end else if (spi_done) begin
                        issued   <= 1'b0;
                        poll_cnt <= poll_nxt;
                        // WIP clear wins even on the last allowed poll.
                        if (!spi_rdata[0]) begin
                            state   <= S_DONE;
                            op_done <= 1'b1;
                            op_err  <= 1'b0;
                        end else if (poll_nxt == POLL_LAST) begin
                            state   <= S_DONE;
                            op_done <= 1'b1;
                            op_err  <= 1'b1;
                        end else begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_op_sequencer.sv
// tb/tb_flash_op_sequencer.sv - self-checking bench for flash_op_sequencer
module tb_flash_op_sequencer;
    localparam int POLL_GAP  = 4;
    localparam int MAX_POLLS = 4;
    localparam int PCW       = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [23:0] req_addr;
    logic [3:0]  req_len;
    logic        op_done;
    logic        op_err;
    logic        spi_start;
    logic [7:0]  spi_opcode;
    logic [23:0] spi_addr;
    logic [3:0]  spi_len;
    logic        spi_rw;
    logic        spi_busy;
    logic        spi_done;
    logic [7:0]  spi_rdata;

    logic force_busy;
    logic xfer_busy;
    assign spi_busy = force_busy | xfer_busy;

    flash_op_sequencer #(
        .POLL_GAP (POLL_GAP),
        .MAX_POLLS(MAX_POLLS),
        .PCW      (PCW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .op_done   (op_done),
        .op_err    (op_err),
        .spi_start (spi_start),
        .spi_opcode(spi_opcode),
        .spi_addr  (spi_addr),
        .spi_len   (spi_len),
        .spi_rw    (spi_rw),
        .spi_busy  (spi_busy),
        .spi_done  (spi_done),
        .spi_rdata (spi_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  opc;
        logic [23:0] addr;
        logic [3:0]  len;
        logic        rw;
    } cmd_t;

    typedef struct {
        int   cyc;
        cmd_t cmd;
    } start_t;

    typedef struct {
        logic [1:0]  op;
        logic [23:0] addr;
        logic [3:0]  len;
        int          lat;
        logic [47:0] st;          // RDSR replies, byte k = reply to poll k
        int          hold;        // cycles spi_busy is forced high around accept
        int          exp_starts;  // -1 = take from model only
        int          exp_err;     // -1 = take from model only
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    string cur_tag = "reset";

    // Controller model state
    int         cyc = 0;
    int         lat_cfg = 1;
    logic       pend = 1'b0;
    int         done_at = 0;
    logic       busy_edge;
    start_t     rec;
    logic [7:0] stat_q[$];
    start_t     starts_q[$];
    int         opdone_cnt = 0;
    int         opdone_cyc = 0;
    logic       opdone_err = 1'b0;
    int         spidone_cnt = 0;
    int         last_spidone_cyc = 0;

    // Reference model output
    cmd_t exp_q[$];
    logic exp_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s/%s: got %0h expected %0h", cur_tag, name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic cmd_t mk(input logic [7:0] o, input logic [23:0] a, input logic [3:0] l,
                                input logic r);
        cmd_t c;
        c = {o, a, l, r};
        return c;
    endfunction

    // Expected SPI command list and error flag, straight from the operation rules.
    task automatic build_model(input logic [1:0] op, input logic [23:0] a, input logic [3:0] l,
                               input logic [47:0] st);
        exp_q.delete();
        exp_err = 1'b1;
        if (op == 2'd0) begin
            exp_q.push_back(mk(8'h03, a, l, 1'b1));
            exp_err = 1'b0;
        end else if (op != 2'd3) begin
            exp_q.push_back(mk(8'h06, 24'd0, 4'd0, 1'b0));
            if (op == 2'd1) exp_q.push_back(mk(8'h02, a, l, 1'b0));
            else            exp_q.push_back(mk(8'h20, a, 4'd0, 1'b0));
            for (int k = 0; k < MAX_POLLS; k++) begin
                logic [7:0] s;
                s = (k < 6) ? st[8*k +: 8] : 8'h00;
                exp_q.push_back(mk(8'h05, 24'd0, 4'd1, 1'b1));
                if (s[0] == 1'b0) begin
                    exp_err = 1'b0;
                    break;
                end
            end
        end
    endtask

    // SPI controller model and monitor; acts 1 time unit after each rising edge.
    initial begin
        spi_done  = 1'b0;
        spi_rdata = 8'h00;
        xfer_busy = 1'b0;
        forever begin
            @(posedge clk);
            busy_edge = spi_busy;
            #1;
            cyc++;
            spi_done = 1'b0;
            if (op_done === 1'b1) begin
                opdone_cnt++;
                opdone_cyc = cyc;
                opdone_err = op_err;
            end
            if (pend && cyc == done_at) begin
                chk("fields held to done", {spi_opcode, spi_addr, spi_len, spi_rw}, rec.cmd);
                spi_done = 1'b1;
                pend = 1'b0;
                xfer_busy = 1'b0;
                spidone_cnt++;
                last_spidone_cyc = cyc;
                if (rec.cmd.opc == 8'h05)
                    spi_rdata = (stat_q.size() > 0) ? stat_q.pop_front() : 8'h00;
                else
                    spi_rdata = 8'($urandom);
            end
            if (spi_start === 1'b1) begin
                chk("start while busy", busy_edge, 0);
                chk("start overlaps transfer", pend, 0);
                if (spi_opcode == 8'h05)
                    chk("rdsr gap", cyc - last_spidone_cyc, POLL_GAP + 1);
                rec.cyc = cyc;
                rec.cmd = {spi_opcode, spi_addr, spi_len, spi_rw};
                starts_q.push_back(rec);
                pend = 1'b1;
                done_at = cyc + lat_cfg;
                xfer_busy = 1'b1;
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int acc_cyc;
        int rel_cyc;
        build_model(v.op, v.addr, v.len, v.st);
        lat_cfg = v.lat;
        stat_q.delete();
        for (int k = 0; k < 6; k++) stat_q.push_back(v.st[8*k +: 8]);
        starts_q.delete();
        opdone_cnt = 0;
        spidone_cnt = 0;
        for (int i = 0; i < 100 && req_ready !== 1'b1; i++) tick();
        chk("ready before request", req_ready, 1);
        if (v.hold > 0) force_busy = 1'b1;
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_len   = v.len;
        acc_cyc   = cyc;
        tick();
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = 24'($urandom);
        req_len   = 4'($urandom);
        rel_cyc = 0;
        if (v.hold > 0) begin
            for (int i = 1; i < v.hold; i++) tick();
            chk("no start while busy held", starts_q.size(), 0);
            force_busy = 1'b0;
            rel_cyc = cyc;
        end
        for (int i = 0; i < 600 && opdone_cnt == 0; i++) tick();
        chk("op_done seen", opdone_cnt, 1);
        if (opdone_cnt != 0) begin
            chk("req_ready low in done", req_ready, 0);
            tick();
            chk("op_done single cycle", op_done, 0);
            chk("req_ready back high", req_ready, 1);
        end
        repeat (2 * POLL_GAP + v.lat + 4) tick();
        chk("start count vs model", starts_q.size(), exp_q.size());
        if (v.exp_starts >= 0) chk("start count vs table", starts_q.size(), v.exp_starts);
        for (int i = 0; i < exp_q.size() && i < starts_q.size(); i++)
            chk($sformatf("cmd %0d", i), starts_q[i].cmd, exp_q[i]);
        chk("op_err vs model", opdone_err, exp_err);
        if (v.exp_err >= 0) chk("op_err vs table", opdone_err, v.exp_err);
        chk("op_done count", opdone_cnt, 1);
        chk("op_err held", op_err, exp_err);
        if (exp_q.size() > 0) chk("opcode held in idle", spi_opcode, exp_q[exp_q.size()-1].opc);
        if (v.op == 2'd0 && starts_q.size() > 0) begin
            if (v.hold == 0) chk("read start latency", starts_q[0].cyc - acc_cyc, 1);
            chk("read done latency", opdone_cyc - last_spidone_cyc, 1);
        end
        if (v.op == 2'd3) chk("reserved done latency", opdone_cyc - acc_cyc, 1);
        if (v.hold > 0 && starts_q.size() > 0)
            chk("start after busy release", starts_q[0].cyc - rel_cyc, 1);
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2'd0, 24'h001000, 4'd4, 10, 48'h0,              0,  1, 0};
        tbl[1] = '{2'd1, 24'h0A0B0C, 4'd8, 3,  48'h000000_000101,  0,  5, 0};
        tbl[2] = '{2'd2, 24'h123456, 4'd5, 2,  48'h030303_030303,  0,  6, 1};
        tbl[3] = '{2'd1, 24'h00FF00, 4'd2, 1,  48'h0,              20, 3, 0};
        tbl[4] = '{2'd3, 24'h000000, 4'd0, 1,  48'h0,              0,  0, 1};
        tbl[5] = '{2'd2, 24'h7FFFFF, 4'd3, 4,  48'h000000_010101,  0,  6, 0};
        tbl[6] = '{2'd0, 24'hFFFFFF, 4'd0, 1,  48'h0,              0,  1, 0};
        tbl[7] = '{2'd1, 24'h000001, 4'hF, 2,  48'h000000_0000FE,  0,  3, 0};

        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 2'd0;
        req_addr = 24'd0;
        req_len = 4'd0;
        force_busy = 1'b0;
        repeat (3) tick();
        chk("rst req_ready", req_ready, 1);
        chk("rst op_done", op_done, 0);
        chk("rst op_err", op_err, 0);
        chk("rst spi_start", spi_start, 0);
        chk("rst spi_opcode", spi_opcode, 0);
        chk("rst spi_addr", spi_addr, 0);
        chk("rst spi_len", spi_len, 0);
        chk("rst spi_rw", spi_rw, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            cur_tag = $sformatf("vec%0d", i);
            run_vec(tbl[i]);
        end

        // Reset in the middle of a program's poll gap.
        cur_tag = "reset_mid_op";
        lat_cfg = 2;
        stat_q.delete();
        for (int k = 0; k < 6; k++) stat_q.push_back(8'h01);
        starts_q.delete();
        opdone_cnt = 0;
        spidone_cnt = 0;
        req_valid = 1'b1;
        req_op = 2'd1;
        req_addr = 24'h00ABCD;
        req_len = 4'd6;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 100 && spidone_cnt < 2; i++) tick();
        chk("program cmd finished", spidone_cnt, 2);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid rst req_ready", req_ready, 1);
        chk("mid rst spi_start", spi_start, 0);
        chk("mid rst spi_opcode", spi_opcode, 0);
        chk("mid rst spi_addr", spi_addr, 0);
        chk("mid rst spi_len", spi_len, 0);
        chk("mid rst spi_rw", spi_rw, 0);
        chk("mid rst op_err", op_err, 0);
        rst = 1'b0;
        pend = 1'b0;
        xfer_busy = 1'b0;
        stat_q.delete();
        repeat (12) tick();
        chk("no op_done after reset", opdone_cnt, 0);
        chk("no start after reset", starts_q.size(), 2);
        cur_tag = "read_after_reset";
        run_vec('{2'd0, 24'h000200, 4'd3, 5, 48'h0, 0, 1, 0});

        // Randomized operations checked against the model.
        for (int n = 0; n < 30; n++) begin
            cur_tag = $sformatf("rand%0d", n);
            rv.op   = 2'($urandom_range(0, 3));
            rv.addr = 24'($urandom);
            rv.len  = 4'($urandom);
            rv.lat  = $urandom_range(1, 6);
            for (int k = 0; k < 6; k++)
                rv.st[8*k +: 8] = {7'($urandom), ($urandom_range(0, 3) != 0)};
            rv.hold = 0;
            rv.exp_starts = -1;
            rv.exp_err = -1;
            run_vec(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
